truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that exhaustively drives every input combination into an external N_IN-input combinational function under test (the 4-input POS gate blocks in this lab set). It samples the function output after a programmable settle time and assembles the captured truth table. The captured table is compared against an expected vector. This block replaces hand-written per-vector testbench stimulus, and sits between the bench or top level and the gate block.

Parameters:
N_IN, 4, number of function inputs; vector count V = 2**N_IN
SETTLE, 2, clock cycles each vector is held before sampling; legal range ≥1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep; sampled only in RUN
expected  input  V  expected table; bit i = required f(i); latched on accepted start
dut_in  output  N_IN  vector driven to the function; index i = {a,b,c,d} with a = MSB
dut_out  input  1  function output
busy  output  1  high in RUN
done  output  1  one-cycle pulse on sweep completion
pass  output  1  captured table == latched expected; valid from done, held until next accepted start
table_out  output  V  captured table; bit i = dut_out sampled for vector i
fail_valid  output  1  at least one mismatch seen
first_fail  output  N_IN  lowest mismatching index; meaningful only when fail_valid=1

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, cnt=0. All outputs 0: dut_in, busy, done, pass, table_out, fail_valid, first_fail.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - next state RUN; latch expected into exp_q.
  - clear table_out, pass, fail_valid, first_fail.
  - set idx=0, cnt=0, dut_in=0, busy=1.
- RUN, each edge, abort=0:
  - if cnt<SETTLE-1, cnt++.
  - else capture: table_out[idx]<=dut_out.
    - If dut_out!=exp_q[idx] and fail_valid=0: fail_valid<=1, first_fail<=idx.
    - If idx==V-1: go to DONE, busy<=0, done<=1. pass<=1 only if no mismatch, including this final capture.
    - Else idx++, dut_in<=idx+1, cnt<=0.
- Timing: capture for vector k occurs at edge E0+SETTLE*(k+1). done is high during the cycle after edge E0+SETTLE*V (defaults: edge E0+32).
- dut_in changes only on capture edges (and on start/reset). It is held stable for exactly SETTLE cycles per vector.
- DONE: done=1 for one cycle, then IDLE unconditionally. dut_in keeps V-1.
  - start asserted during DONE is ignored.
  - table_out, pass, fail_valid, first_fail are held until the next accepted start.
- abort=1 in RUN (takes priority over a capture on the same edge):
  - go to IDLE, busy<=0, dut_in<=0, no done pulse, pass=0.
  - table_out keeps partial contents; fail_valid/first_fail keep their values.
- abort in IDLE/DONE: ignored. start in RUN: ignored; exp_q does not change.
- Changes on expected after start have no effect.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse.
- idx width N_IN; cnt width clog2(SETTLE)+1; no wrap of idx beyond V-1.

Test Plan:
- DUT = 4-input POS function, zeros at {0,1,6,7,8,9,12,14}; expected=16'hAC3C; start at E0 -> busy high 32 cycles, done pulse after E0+32, table_out=16'hAC3C, pass=1, fail_valid=0.
- Same DUT, expected=16'hAC3D -> pass=0, fail_valid=1, first_fail=0, table_out=16'hAC3C. Then expected=16'h2C3C -> first_fail=15, pass=0.
- Monitor dut_in: sequence 0,1,…,15, each value held exactly 2 cycles. Rerun with SETTLE=1: held 1 cycle, done after E0+16, same table.
- abort at E0+10 -> busy=0 next cycle, dut_in=0, no done within 40 cycles, pass=0; table_out bits 0..3 captured (0x000C), higher bits 0.
- start pulsed at E0+5 with expected changed to 0 -> ignored, result still pass=1; start during DONE cycle -> no new sweep.
- rst_n low at E0+20 -> all outputs 0 immediately (before next edge); new start after release runs a full sweep to pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Exhaustive stimulus sequencer for an N_IN-input combinational
//                function. Drives every input vector in ascending order,
//                holds each for SETTLE cycles, samples the function output on
//                the last cycle of the hold window and assembles the captured
//                truth table. The table is compared against an expected
//                vector that is latched when the sweep is accepted.
//
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                start      begin a sweep (honoured only while idle)
//                abort      cancel a running sweep (honoured only in RUN)
//                expected   expected table, bit i = required f(i)
//                dut_in     vector driven to the function, {a,b,c,d}, a = MSB
//                dut_out    function output
//                busy       high while the sweep is running
//                done       one-cycle pulse when a sweep completes
//                pass       captured table equals latched expected table
//                table_out  captured table, bit i = f(i) as sampled
//                fail_valid at least one mismatch has been seen
//                first_fail lowest mismatching vector index
//
//  Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 fail_valid,
    output logic [N_IN-1:0]      first_fail
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_num_vec  = 2**N_IN;
    localparam int                c_cnt_w    = $clog2(SETTLE) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE - 1);
    localparam logic [N_IN-1:0]   c_idx_last = N_IN'(c_num_vec - 1);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [c_num_vec-1:0] r_exp;        // expected table latched at start
    logic [c_num_vec-1:0] r_table;      // captured table
    logic [N_IN-1:0]      r_idx;        // current vector; also drives dut_in
    logic [c_cnt_w-1:0]   r_cnt;        // cycles elapsed within the hold window
    logic                 r_pass;
    logic                 r_fail_valid;
    logic [N_IN-1:0]      r_first_fail;

    // ------------------------------------------------------------------------
    // Qualified events
    // ------------------------------------------------------------------------
    logic w_start_ok;
    logic w_abort_ok;
    logic w_capture;
    logic w_last_vec;
    logic w_mismatch;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_abort_ok = (r_state == S_RUN) && abort;
    // Abort wins over a capture scheduled for the same edge.
    assign w_capture  = (r_state == S_RUN) && !abort && (r_cnt >= c_cnt_last);
    assign w_last_vec = (r_idx == c_idx_last);
    assign w_mismatch = (dut_out != r_exp[r_idx]);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_capture && w_last_vec) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Single-cycle completion pulse; start is not looked at here.
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sweep datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp        <= '0;
            r_table      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else if (w_start_ok) begin
            r_exp        <= expected;
            r_table      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else if (w_abort_ok) begin
            // Partial table and mismatch record are left for inspection.
            r_idx  <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!w_capture) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_table[r_idx] <= dut_out;
                if (w_mismatch && !r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_first_fail <= r_idx;
                end
                if (w_last_vec) begin
                    // The final sample is folded in directly because
                    // r_fail_valid has not yet absorbed it.
                    r_pass <= !(r_fail_valid || w_mismatch);
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_cnt <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The vector index itself is the stimulus: it only moves on capture,
    // start, abort and reset, and it parks at the last vector after DONE.
    assign dut_in     = r_idx;
    assign pass       = r_pass;
    assign table_out  = r_table;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sweeper
//  Description : Self-checking bench for truth_table_sweeper. Two instances
//                (SETTLE=2 and SETTLE=1) each drive a 4-input POS function
//                with zeros at {0,1,6,7,8,9,12,14}. Expected sweep outcomes
//                are queued when a sweep is launched and compared when it
//                completes or is aborted.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [15:0] expected;

    logic [3:0]  dut_in_a, dut_in_b, first_fail_a, first_fail_b;
    logic        dut_out_a, dut_out_b;
    logic        busy_a, done_a, pass_a, fail_valid_a;
    logic        busy_b, done_b, pass_b, fail_valid_b;
    logic [15:0] table_out_a, table_out_b;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic        fv;
        logic [3:0]  ff;
    } exp_t;

    exp_t sb[$];

    // Reference function under test: product-of-sums with these zeros.
    function automatic logic model_f(input logic [3:0] v);
        case (v)
            4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd14: model_f = 1'b0;
            default:                                          model_f = 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] model_table();
        logic [15:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[i] = model_f(4'(i));
        return t;
    endfunction

    assign dut_out_a = model_f(dut_in_a);
    assign dut_out_b = model_f(dut_in_b);

    truth_table_sweeper #(.N_IN(4), .SETTLE(2)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .abort      (abort_a),
        .expected   (expected),
        .dut_in     (dut_in_a),
        .dut_out    (dut_out_a),
        .busy       (busy_a),
        .done       (done_a),
        .pass       (pass_a),
        .table_out  (table_out_a),
        .fail_valid (fail_valid_a),
        .first_fail (first_fail_a)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .abort      (abort_b),
        .expected   (expected),
        .dut_in     (dut_in_b),
        .dut_out    (dut_out_b),
        .busy       (busy_b),
        .done       (done_b),
        .pass       (pass_b),
        .table_out  (table_out_b),
        .fail_valid (fail_valid_b),
        .first_fail (first_fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Generic sweep: sel=0 -> instance A (SETTLE=2), sel=1 -> B (SETTLE=1).
    // abort_n : edge (relative to E0) at which abort is sampled, -1 = none
    // poke_n  : after the sample of this edge, pulse start with expected=0
    // extra   : cycles observed beyond completion/abort
    // ------------------------------------------------------------------------
    task automatic run_sweep(input bit sel, input logic [15:0] exp_vec,
                             input int abort_n, input int poke_n, input int extra);
        int          settle, end_n, ncap;
        logic [15:0] mtab, mask, diff;
        exp_t        e, cur;
        logic [3:0]  o_din, o_ff, e_din;
        logic        o_busy, o_done, o_pass, o_fv, e_busy, e_done;
        logic [15:0] o_tab;

        settle = sel ? 1 : 2;
        mtab   = model_table();
        if (abort_n >= 0) begin
            end_n = abort_n;
            ncap  = (abort_n - 1) / settle;
            mask  = 16'((32'd1 << ncap) - 1);
        end else begin
            end_n = settle * 16;
            mask  = 16'hFFFF;
        end
        e.tbl  = mtab & mask;
        diff   = (mtab ^ exp_vec) & mask;
        e.fv   = (diff != 0);
        e.pass = (abort_n < 0) && (diff == 0);
        e.ff   = 4'd0;
        for (int i = 15; i >= 0; i--) if (diff[i]) e.ff = 4'(i);
        sb.push_back(e);
        cur = e;

        expected = exp_vec;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;

        for (int n = 0; n <= end_n + extra; n++) begin
            o_din  = sel ? dut_in_b     : dut_in_a;
            o_busy = sel ? busy_b       : busy_a;
            o_done = sel ? done_b       : done_a;
            o_pass = sel ? pass_b       : pass_a;
            o_fv   = sel ? fail_valid_b : fail_valid_a;
            o_ff   = sel ? first_fail_b : first_fail_a;
            o_tab  = sel ? table_out_b  : table_out_a;

            e_busy = (n < end_n);
            e_done = (abort_n < 0) && (n == end_n);
            if (n < end_n)       e_din = 4'(n / settle);
            else if (abort_n>=0) e_din = 4'd0;
            else                 e_din = 4'd15;

            n_run++;
            if (o_busy !== e_busy) begin
                n_fail++;
                $display("FAIL busy sel=%0d n=%0d got %b want %b", sel, n, o_busy, e_busy);
            end
            n_run++;
            if (o_done !== e_done) begin
                n_fail++;
                $display("FAIL done sel=%0d n=%0d got %b want %b", sel, n, o_done, e_done);
            end
            n_run++;
            if (o_din !== e_din) begin
                n_fail++;
                $display("FAIL dut_in sel=%0d n=%0d got %0d want %0d", sel, n, o_din, e_din);
            end

            if (n == 0) begin
                n_run++;
                if (o_tab !== 16'h0 || o_pass !== 1'b0 || o_fv !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_clear sel=%0d got tab=%h pass=%b fv=%b want 0000/0/0",
                             sel, o_tab, o_pass, o_fv);
                end
            end

            if (n == end_n) begin
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty sel=%0d got 0 entries want 1", sel);
                end else begin
                    cur = sb.pop_front();
                end
            end

            // Results must be present at completion and held afterwards.
            if (n == end_n || n == end_n + extra) begin
                n_run++;
                if (o_tab !== cur.tbl) begin
                    n_fail++;
                    $display("FAIL table_out sel=%0d n=%0d got %h want %h", sel, n, o_tab, cur.tbl);
                end
                n_run++;
                if (o_pass !== cur.pass) begin
                    n_fail++;
                    $display("FAIL pass sel=%0d n=%0d got %b want %b", sel, n, o_pass, cur.pass);
                end
                n_run++;
                if (o_fv !== cur.fv) begin
                    n_fail++;
                    $display("FAIL fail_valid sel=%0d n=%0d got %b want %b", sel, n, o_fv, cur.fv);
                end
                if (cur.fv) begin
                    n_run++;
                    if (o_ff !== cur.ff) begin
                        n_fail++;
                        $display("FAIL first_fail sel=%0d n=%0d got %0d want %0d", sel, n, o_ff, cur.ff);
                    end
                end
            end

            // Stimulus for the next edge.
            start_a = 1'b0;
            start_b = 1'b0;
            abort_a = 1'b0;
            if (n == abort_n - 1) abort_a = 1'b1;
            if (n == poke_n) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
                expected = 16'h0000;
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        abort_a = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n    = 1'b0;
        start_a  = 1'b0;
        abort_a  = 1'b0;
        start_b  = 1'b0;
        abort_b  = 1'b0;
        expected = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({dut_in_a, busy_a, done_a, pass_a, table_out_a, fail_valid_a, first_fail_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a got din=%h busy=%b done=%b pass=%b tab=%h fv=%b ff=%h want all 0",
                     dut_in_a, busy_a, done_a, pass_a, table_out_a, fail_valid_a, first_fail_a);
        end
        n_run++;
        if ({dut_in_b, busy_b, done_b, pass_b, table_out_b, fail_valid_b, first_fail_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b got din=%h busy=%b done=%b pass=%b tab=%h fv=%b ff=%h want all 0",
                     dut_in_b, busy_b, done_b, pass_b, table_out_b, fail_valid_b, first_fail_b);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_pass_sweep();
        run_sweep(1'b0, 16'hAC3C, -1, -1, 2);
        run_sweep(1'b1, 16'hAC3C, -1, -1, 2);
    endtask

    task automatic test_mismatch();
        run_sweep(1'b0, 16'hAC3D, -1, -1, 1);
        run_sweep(1'b0, 16'h2C3C, -1, -1, 1);
        run_sweep(1'b1, 16'h2C3C, -1, -1, 1);
    endtask

    task automatic test_abort();
        run_sweep(1'b0, 16'hAC3D, 10, -1, 40);
    endtask

    task automatic test_start_ignored();
        run_sweep(1'b0, 16'hAC3C, -1, 4, 1);
        run_sweep(1'b0, 16'hAC3C, -1, 32, 4);
    endtask

    task automatic test_reset_mid();
        expected = 16'hAC3C;
        start_a  = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({dut_in_a, busy_a, done_a, pass_a, table_out_a, fail_valid_a, first_fail_a} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got din=%h busy=%b done=%b pass=%b tab=%h fv=%b ff=%h want all 0",
                     dut_in_a, busy_a, done_a, pass_a, table_out_a, fail_valid_a, first_fail_a);
        end
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            n_run++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle n=%0d got done=%b busy=%b want 0/0", n, done_a, busy_a);
            end
        end
        run_sweep(1'b0, 16'hAC3C, -1, -1, 1);
    endtask

    initial begin
        test_reset();
        test_pass_sweep();
        test_mismatch();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
